// File: rtl/v35_intc_if.sv
// Bus bundle between the CPU core and the V35 interrupt controller.
// It carries the SFR access port, the interrupt sources and the request/acknowledge handshake.
interface v35_intc_if;
    logic       ce_cycle;
    logic [2:0] intp;
    logic [2:0] tm_tick;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_addr;
    logic [7:0] reg_din;
    logic [7:0] reg_dout;
    logic       irq_req;
    logic [7:0] irq_vec;
    logic       irq_ack;
    logic       irq_fini;

    // The core side drives the strobes, pins and ticks, and observes the request.
    modport master (
        output ce_cycle, intp, tm_tick, reg_wr, reg_rd, reg_addr, reg_din,
               irq_ack, irq_fini,
        input  reg_dout, irq_req, irq_vec
    );

    // The controller side.
    modport slave (
        input  ce_cycle, intp, tm_tick, reg_wr, reg_rd, reg_addr, reg_din,
               irq_ack, irq_fini,
        output reg_dout, irq_req, irq_vec
    );
endinterface

// File: rtl/v35_intc.sv
// V35 interrupt controller: six fixed sources (INTP0..2, TM0..2).
// Each source has an xxIC control register (flag, mask, 3-bit priority).
// ISPR is the in-service priority register.
// A two-state request FSM presents one latched vector to the core until it is
// acknowledged or withdrawn.
module v35_intc (
    input  logic          clk,
    input  logic          reset,
    v35_intc_if.slave     bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    // Source index order: 0..2 = INTP0..2, 3..5 = TM0..2.
    localparam int NSRC = 6;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Vector number presented to the core for each source index.
    function automatic logic [7:0] vec_of(input logic [2:0] src);
        logic [7:0] v;
        case (src)
            3'd0:    v = 8'd24;
            3'd1:    v = 8'd25;
            3'd2:    v = 8'd26;
            3'd3:    v = 8'd28;
            3'd4:    v = 8'd29;
            3'd5:    v = 8'd30;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    // ISPR bits that block a source of the given priority: every level 0..prio.
    function automatic logic [7:0] prio_span(input logic [2:0] prio);
        logic [7:0] m;
        case (prio)
            3'd0:    m = 8'h01;
            3'd1:    m = 8'h03;
            3'd2:    m = 8'h07;
            3'd3:    m = 8'h0F;
            3'd4:    m = 8'h1F;
            3'd5:    m = 8'h3F;
            3'd6:    m = 8'h7F;
            3'd7:    m = 8'hFF;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // End-of-interrupt clears the lowest-index set bit; a zero value stays zero.
    function automatic logic [7:0] clear_lowest(input logic [7:0] v);
        return v & (v - 8'd1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0] r_intm;
    logic [7:0] r_ic [NSRC];
    logic [7:0] r_ispr;
    logic [2:0] r_prev;
    state_t     r_state;
    logic [2:0] r_src;
    logic [2:0] r_prio;
    logic       r_irq_req;
    logic [7:0] r_irq_vec;
    logic [7:0] r_reg_dout;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic             w_wr_intm;
    logic [NSRC-1:0]  w_wr_ic;
    logic [7:0]       w_rd_data;
    logic [2:0]       w_edge_set;
    logic [NSRC-1:0]  w_set;
    logic [7:0]       w_elig;
    logic             w_win_found;
    logic [2:0]       w_win_src;
    logic [2:0]       w_win_prio;
    state_t           w_state_nxt;
    logic             w_take;
    logic             w_ack;
    logic [NSRC-1:0]  w_ack_clr;
    logic [7:0]       w_ispr_nxt;
    logic [7:0]       w_ic_nxt [NSRC];

    // Decode SFR writes; unlisted offsets and ISPR are simply not decoded.
    always_comb begin
        w_wr_intm = 1'b0;
        w_wr_ic   = 6'b000000;
        if (bus.reg_wr) begin
            case (bus.reg_addr)
                8'h40:   w_wr_intm  = 1'b1;
                8'h4C:   w_wr_ic[0] = 1'b1;
                8'h4D:   w_wr_ic[1] = 1'b1;
                8'h4E:   w_wr_ic[2] = 1'b1;
                8'h9C:   w_wr_ic[3] = 1'b1;
                8'h9D:   w_wr_ic[4] = 1'b1;
                8'h9E:   w_wr_ic[5] = 1'b1;
                default: w_wr_intm  = 1'b0;
            endcase
        end else begin
            w_wr_intm = 1'b0;
        end
    end

    // Read-data mux; unlisted offsets return zero.
    always_comb begin
        w_rd_data = 8'h00;
        case (bus.reg_addr)
            8'h40:   w_rd_data = r_intm;
            8'h4C:   w_rd_data = r_ic[0];
            8'h4D:   w_rd_data = r_ic[1];
            8'h4E:   w_rd_data = r_ic[2];
            8'h9C:   w_rd_data = r_ic[3];
            8'h9D:   w_rd_data = r_ic[4];
            8'h9E:   w_rd_data = r_ic[5];
            8'hFC:   w_rd_data = r_ispr;
            default: w_rd_data = 8'h00;
        endcase
    end

    // External pins: a change towards the INTM-selected level sets the flag.
    always_comb begin
        w_edge_set = 3'b000;
        for (int n = 0; n < 3; n++) begin
            w_edge_set[n] = bus.ce_cycle
                          && (bus.intp[n] != r_prev[n])
                          && (bus.intp[n] == r_intm[2*n+2]);
        end
        w_set = {bus.tm_tick, w_edge_set};
    end

    // Eligibility and winner selection.
    // A strict less-than keeps the lower index on a priority tie.
    always_comb begin
        w_elig      = 8'h00;
        w_win_found = 1'b0;
        w_win_src   = 3'd0;
        w_win_prio  = 3'd7;
        for (int n = 0; n < NSRC; n++) begin
            w_elig[n] = r_ic[n][7] && !r_ic[n][6]
                     && ((r_ispr & prio_span(r_ic[n][2:0])) == 8'h00);
            if (w_elig[n] && (!w_win_found || (r_ic[n][2:0] < w_win_prio))) begin
                w_win_found = 1'b1;
                w_win_src   = 3'(n);
                w_win_prio  = r_ic[n][2:0];
            end else begin
                w_win_found = w_win_found;
            end
        end
    end

    // Request FSM next state.
    // Ack beats withdrawal, and a pending request is never preempted.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ce_cycle && w_win_found) begin
                    w_state_nxt = S_PEND;
                    w_take      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_PEND: begin
                if (bus.ce_cycle && bus.irq_ack) begin
                    w_ack       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (bus.ce_cycle && !w_elig[r_src]) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_PEND;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ISPR update: apply the fini clear first, then the ack set of the latched priority.
    always_comb begin
        w_ispr_nxt = r_ispr;
        if (bus.ce_cycle && bus.irq_fini) begin
            w_ispr_nxt = clear_lowest(w_ispr_nxt);
        end else begin
            w_ispr_nxt = r_ispr;
        end
        if (w_ack) begin
            w_ispr_nxt = w_ispr_nxt | (8'h01 << r_prio);
        end else begin
            w_ispr_nxt = w_ispr_nxt;
        end
    end

    // Control-register update.
    // Apply the software write, then the ack clear, then the hardware set, so that any set wins the flag.
    always_comb begin
        w_ack_clr = 6'b000000;
        for (int n = 0; n < NSRC; n++) begin
            w_ack_clr[n] = w_ack && (r_src == 3'(n));
            w_ic_nxt[n]  = r_ic[n];
            if (w_wr_ic[n]) begin
                w_ic_nxt[n] = bus.reg_din;
            end else begin
                w_ic_nxt[n] = r_ic[n];
            end
            if (w_ack_clr[n]) begin
                w_ic_nxt[n][7] = 1'b0;
            end else begin
                w_ic_nxt[n][7] = w_ic_nxt[n][7];
            end
            if (w_set[n]) begin
                w_ic_nxt[n][7] = 1'b1;
            end else begin
                w_ic_nxt[n][7] = w_ic_nxt[n][7];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // SFR storage and the pin history used for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_intm <= 8'h00;
            r_ispr <= 8'h00;
            r_prev <= 3'b000;
            for (int n = 0; n < NSRC; n++) begin
                r_ic[n] <= 8'h47;
            end
        end else begin
            if (w_wr_intm) begin
                r_intm <= bus.reg_din;
            end
            r_ispr <= w_ispr_nxt;
            if (bus.ce_cycle) begin
                r_prev <= bus.intp;
            end
            for (int n = 0; n < NSRC; n++) begin
                r_ic[n] <= w_ic_nxt[n];
            end
        end
    end

    // Latched request: the source, priority and vector are captured when the FSM leaves IDLE.
    // The vector holds after a withdrawal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src     <= 3'd0;
            r_prio    <= 3'd0;
            r_irq_vec <= 8'h00;
            r_irq_req <= 1'b0;
        end else begin
            if (w_take) begin
                r_src     <= w_win_src;
                r_prio    <= w_win_prio;
                r_irq_vec <= vec_of(w_win_src);
            end
            r_irq_req <= (w_state_nxt == S_PEND);
        end
    end

    // Registered read data: it loads on a read strobe and holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_dout <= 8'h00;
        end else if (bus.reg_rd) begin
            r_reg_dout <= w_rd_data;
        end
    end

    assign bus.reg_dout = r_reg_dout;
    assign bus.irq_req  = r_irq_req;
    assign bus.irq_vec  = r_irq_vec;

endmodule

// File: doc/v35_intc.md
V35_INTC -- requirements
Module: v35_intc

Interface
REQ-001 Parameter: none; the source set is fixed at 6 (INTP0, INTP1, INTP2, TM0, TM1, TM2).
REQ-002 clk  in  1  system clock; sole clock, all state on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 ce_cycle  in  1  CPU internal-cycle enable; qualifies interrupt sequencing.
REQ-005 intp  in  3  external interrupt pins INTP2..0, level inputs, sampled on ce_cycle.
REQ-006 tm_tick  in  3  timer 0/1/2 expiry, 1-clk pulses, any clock.
REQ-007 reg_wr / reg_rd  in  1 / 1  SFR write / read strobes, same-clock, mutually exclusive.
REQ-008 reg_addr  in  8  SFR offset; reg_din  in  8  write data.
REQ-009 reg_dout  out  8  registered read data.
REQ-010 irq_req  out  1  interrupt request to CPU core.
REQ-011 irq_vec  out  8  vector number of the pending request.
REQ-012 irq_ack  in  1  core acceptance pulse, valid only with ce_cycle.
REQ-013 irq_fini  in  1  core end-of-interrupt (RETI) pulse, valid only with ce_cycle.

Function
REQ-014 Registers: INTM @0x40; EXIC0-2 @0x4C-0x4E; TMIC0-2 @0x9C-0x9E; ISPR @0xFC (read-only; writes ignored).
REQ-015 Control-register format (xxIC): bit7 = request flag, bit6 = mask (1 = masked), bits2:0 = priority (0 highest); bits5:3 read back as written.
REQ-016 Register writes take effect on the clock of reg_wr, independent of ce_cycle; writes to unlisted offsets are ignored.
REQ-017 A read loads reg_dout on the clock of reg_rd; unlisted offsets return 0x00; reg_dout holds its value otherwise.
REQ-018 External edge detection, on each ce_cycle:
  - prev[n] <= intp[n].
  - If intp[n] != prev[n] and intp[n] == INTM[2n+2], EXICn[7] is set.
  - INTM[2], INTM[4] and INTM[6] select the active level for INTP0, INTP1 and INTP2 respectively.
REQ-019 Timer flags: a tm_tick[n] pulse sets TMICn[7] on that clock.
REQ-020 Eligibility: a source is eligible when all of the following hold:
  - flag = 1;
  - mask = 0;
  - ISPR[k] = 0 for all k <= that source's priority.
REQ-021 Selection: among eligible sources, the lowest priority value wins; ties go to the lower source index (order INTP0, INTP1, INTP2, TM0, TM1, TM2).
REQ-022 Vectors: INTP0..2 = 24, 25, 26; TM0..2 = 28, 29, 30.
REQ-023 FSM IDLE: on a ce_cycle with a winner, latch the source id, irq_vec and the winner's ISPR bit; go to PEND and set irq_req = 1.
REQ-024 FSM PEND, irq_ack on ce_cycle:
  - the latched ISPR bit is set;
  - the latched source flag is cleared;
  - irq_req = 0; go to IDLE.
REQ-025 FSM PEND, no ack: if the latched source becomes ineligible (flag cleared or mask set by software), drop irq_req on the next ce_cycle and go to IDLE; irq_vec holds its value.
REQ-026 In PEND, a higher-priority source does not preempt the latched request; it is re-evaluated after returning to IDLE.
REQ-027 irq_fini on ce_cycle clears the lowest-index set ISPR bit; with ISPR = 0 it has no effect.
REQ-028 Same-clock irq_fini and irq_ack: the fini clear is applied first, then the ack set.
REQ-029 Flag-set precedence: a hardware set (edge or tick) and a software write to the same xxIC on the same clock give flag = 1; the other bits take the written value.
REQ-030 Ack precedence: if irq_ack and a new set event for the same source occur on the same clock, the flag remains 1.
REQ-031 Latency: a flag set on clock T (with the FSM IDLE) asserts irq_req on the first ce_cycle after T.

Reset
REQ-032 On reset, outputs and state take these values:
  - INTM = 0x00; all six xxIC = 0x47; ISPR = 0x00;
  - prev = 3'b000; FSM = IDLE;
  - irq_req = 0; irq_vec = 0x00; reg_dout = 0x00.
REQ-033 Reset asserted mid-PEND drops irq_req in the same cycle, without waiting for a clock edge.

Verification
REQ-034 Basic request: INTM = 0x00, EXIC0 = 0x00; drive intp[0] 1->0 -> irq_req = 1 and irq_vec = 24; send irq_ack -> ISPR = 0x01, EXIC0 reads 0x00.
REQ-035 Tie-break: EXIC1 = 0x03 and TMIC0 = 0x03; pulse both sources together -> irq_vec = 25 first; after ack, TM0 is held off until fini (ISPR = 0x08); after fini -> irq_vec = 28.
REQ-036 Priority: with ISPR = 0x04 (in service), a priority-1 source is accepted, then fini gives ISPR = 0x04; a priority-5 request stays blocked until a second fini.
REQ-037 Withdrawal: in PEND, software writes EXIC0 = 0x40 -> irq_req = 0 on the next ce_cycle; ISPR unchanged.
REQ-038 Async reset: assert reset mid-PEND -> irq_req = 0 immediately; reads return EXIC0 = 0x47 and ISPR = 0x00.
